i8288_busctl: RTL and testbench
===============================

Name: i8288_busctl

Overview:
- Simplified i8288 bus controller for the i8088 breadboard computer.
- Sits directly downstream of the clock generator. It runs on the generated CPU clock and is held in reset by the generator's RESET output.
- Decodes the CPU status lines S2..S0 into a T1..T4 bus-cycle state machine.
- Produces ALE, the active-low memory/I-O/INTA command strobes, and DEN/DT_R for the data transceivers.
- Adds an optional bus-timeout watchdog.

Parameters:
- TIMEOUT_CYCLES, 0: maximum cycles spent in T3/Tw before the cycle is aborted; 0 disables the watchdog.
- HALT_ALE, 1: when 1, a halt status still produces an ALE pulse in T1; when 0, no ALE on halt.

Ports:
- CLK  in  1  CPU clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- STATUS  in  3  CPU S2..S0: 000 INTA, 001 IORD, 010 IOWR, 011 HALT, 100 CODE, 101 MEMRD, 110 MEMWR, 111 passive.
- CEN  in  1  command enable; 0 forces command strobes and DEN inactive.
- ALE  out  1  address latch enable, high for the T1 cycle.
- MRDC_N  out  1  memory read command (CODE, MEMRD).
- MWTC_N  out  1  memory write command.
- IORC_N  out  1  I/O read command.
- IOWC_N  out  1  I/O write command.
- INTA_N  out  1  interrupt acknowledge.
- DEN  out  1  data transceiver enable, active high.
- DT_R  out  1  transceiver direction: 1 transmit (write), 0 receive.
- BUS_TO  out  1  one-cycle pulse when the watchdog aborts a cycle.

Behaviour:
- Reset:
  - State goes to IDLE; ALE=0; all *_N=1; DEN=0; DT_R=1; BUS_TO=0; timeout counter=0.
  - RESET asserted mid-cycle releases every strobe on the next edge.
  - The cycle in progress is abandoned and not resumed.
- All outputs are registered. STATUS is sampled on every rising edge. Latency from status leaving 111 to ALE=1 is one cycle.
- State IDLE:
  - Outputs are inactive.
  - STATUS==111: stay.
  - Otherwise latch STATUS into cmd_r and go to T1.
- State T1:
  - ALE=1, except for HALT when HALT_ALE=0.
  - DT_R=0 for read/INTA/CODE types, 1 for write types.
  - STATUS is ignored (cmd_r holds the latched value).
  - Always go to T2.
- State T2:
  - ALE=0.
  - Read-type strobe (MRDC_N/IORC_N/INTA_N) goes low.
  - DEN=1 for all non-HALT types.
  - Write strobes stay high (see Optional Feature).
  - Always go to T3.
- State T3 (includes Tw):
  - The strobe for cmd_r is low, writes included.
  - DEN=1.
  - Timeout counter increments each cycle.
  - STATUS==111: go to T4.
  - TIMEOUT_CYCLES>0 and counter==TIMEOUT_CYCLES-1 with STATUS still active: go to ABORT and pulse BUS_TO next cycle.
- State T4:
  - All strobes high; DEN=0; DT_R=1; counter cleared.
  - STATUS!=111 (the CPU drives the next status in T4): latch it and go directly to T1.
  - Otherwise go to IDLE.
- State ABORT:
  - Strobes high; DEN=0; DT_R=1; BUS_TO=1 for the first cycle only.
  - Stay until STATUS==111, then go to IDLE. No new cycle starts from ABORT.
- HALT:
  - Follows T1 to T2 to T3 with no strobe and DEN=0.
  - Leaves T3 when STATUS==111, like any other type.
  - The watchdog is not applied to HALT.
- CEN:
  - Gates all strobes and DEN every cycle.
  - Dropping CEN mid-command releases them on the next edge.
  - The state machine, ALE and DT_R are unaffected.
- At most one strobe is low at any time. Strobes change only on clock edges and never glitch.
- Counter width is clog2(TIMEOUT_CYCLES+1), minimum 1. The counter saturates and does not wrap.

Optional Feature:
- Macro I8288_ADV_WR_EN.
- Defined: MWTC_N/IOWC_N are asserted from T2 together with read strobes (advanced write).
- Undefined: write strobes assert from T3 only; T2 holds them high.
- Read timing is identical in both builds.

Test Plan:
- RESET=1 for 3 cycles with STATUS=101 → all *_N=1, ALE=0, DEN=0, DT_R=1, BUS_TO=0; the first cycle starts only after RESET drops.
- STATUS 111→101 for 3 cycles, then 111 → ALE=1 in T1, MRDC_N=0 in T2 and T3, DT_R=0 from T1, DEN=1 in T2–T3, all released in T4; IDLE after.
- STATUS=110 held 4 cycles (one Tw), CEN=1 → DT_R=1, MWTC_N=0 starting in T3 (from T2 with I8288_ADV_WR_EN), held through Tw, released in T4.
- Back-to-back cycles: IORD, then STATUS=010 driven during T4 → T4 goes straight to T1; second ALE pulse one cycle after T4; IORC_N and IOWC_N never low together.
- TIMEOUT_CYCLES=4, STATUS=001 held 20 cycles → IORC_N low 4 T3 cycles, then ABORT: BUS_TO single-cycle pulse, strobes high; IDLE only after STATUS returns to 111.
- CEN=0 during an INTA cycle (000) → ALE pulses; INTA_N and DEN stay inactive; state sequence unchanged. HALT (011) with HALT_ALE=0 → no ALE, no strobe.

Source files
------------

// File: rtl/i8288_busctl.sv
// Simplified i8288 bus controller: decodes S2..S0 into a T1..T4 bus cycle with registered strobes.
// Optional advanced write strobes from T2 when I8288_ADV_WR_EN is defined.
module i8288_busctl #(
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter bit          HALT_ALE       = 1'b1
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [2:0] status_i,
    input  logic       cen_i,
    output logic       ale_o,
    output logic       mrdc_n_o,
    output logic       mwtc_n_o,
    output logic       iorc_n_o,
    output logic       iowc_n_o,
    output logic       inta_n_o,
    output logic       den_o,
    output logic       dt_r_o,
    output logic       bus_to_o
);
    localparam int unsigned CNT_W   = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
`ifdef I8288_ADV_WR_EN
    localparam bit          ADV_WR  = 1'b1;
`else
    localparam bit          ADV_WR  = 1'b0;
`endif

    localparam logic [2:0] ST_INTA  = 3'b000;
    localparam logic [2:0] ST_IORD  = 3'b001;
    localparam logic [2:0] ST_IOWR  = 3'b010;
    localparam logic [2:0] ST_HALT  = 3'b011;
    localparam logic [2:0] ST_CODE  = 3'b100;
    localparam logic [2:0] ST_MEMRD = 3'b101;
    localparam logic [2:0] ST_MEMWR = 3'b110;
    localparam logic [2:0] ST_PASV  = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE, S_T1, S_T2, S_T3, S_T4, S_ABORT
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       cmd_q, cmd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic ale_d, mrdc_n_d, mwtc_n_d, iorc_n_d, iowc_n_d, inta_n_d, den_d, dt_r_d, bus_to_d;
    logic is_read, is_write, is_halt, in_cycle, strobe_on;

    // State, latched command, watchdog counter and output registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            cmd_q    <= ST_PASV;
            cnt_q    <= '0;
            ale_o    <= 1'b0;
            mrdc_n_o <= 1'b1;
            mwtc_n_o <= 1'b1;
            iorc_n_o <= 1'b1;
            iowc_n_o <= 1'b1;
            inta_n_o <= 1'b1;
            den_o    <= 1'b0;
            dt_r_o   <= 1'b1;
            bus_to_o <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            cnt_q    <= cnt_d;
            ale_o    <= ale_d;
            mrdc_n_o <= mrdc_n_d;
            mwtc_n_o <= mwtc_n_d;
            iorc_n_o <= iorc_n_d;
            iowc_n_o <= iowc_n_d;
            inta_n_o <= inta_n_d;
            den_o    <= den_d;
            dt_r_o   <= dt_r_d;
            bus_to_o <= bus_to_d;
        end
    end

    // Next state; the counter only survives while the cycle stays in T3
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        cnt_d   = '0;
        case (state_q)
            S_IDLE: begin
                if (status_i != ST_PASV) begin
                    cmd_d   = status_i;
                    state_d = S_T1;
                end
            end
            S_T1: state_d = S_T2;
            S_T2: state_d = S_T3;
            S_T3: begin
                if (status_i == ST_PASV) begin
                    state_d = S_T4;
                end else if (TO_EN && (cmd_q != ST_HALT) && (cnt_q == CNT_W'(TO_LAST))) begin
                    state_d = S_ABORT;
                end else begin
                    cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
                end
            end
            S_T4: begin
                if (status_i != ST_PASV) begin
                    cmd_d   = status_i;
                    state_d = S_T1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ABORT: begin
                if (status_i == ST_PASV) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state so every output lands on the same edge
    always_comb begin
        is_read   = (cmd_d == ST_INTA) || (cmd_d == ST_IORD) || (cmd_d == ST_CODE) || (cmd_d == ST_MEMRD);
        is_write  = (cmd_d == ST_IOWR) || (cmd_d == ST_MEMWR);
        is_halt   = (cmd_d == ST_HALT);
        in_cycle  = (state_d == S_T1) || (state_d == S_T2) || (state_d == S_T3);
        strobe_on = cen_i && !is_halt &&
                    ((state_d == S_T3) || ((state_d == S_T2) && (is_read || (ADV_WR && is_write))));
        ale_d     = (state_d == S_T1) && (HALT_ALE || !is_halt);
        dt_r_d    = !(in_cycle && is_read);
        den_d     = cen_i && !is_halt && ((state_d == S_T2) || (state_d == S_T3));
        mrdc_n_d  = !(strobe_on && ((cmd_d == ST_CODE) || (cmd_d == ST_MEMRD)));
        mwtc_n_d  = !(strobe_on && (cmd_d == ST_MEMWR));
        iorc_n_d  = !(strobe_on && (cmd_d == ST_IORD));
        iowc_n_d  = !(strobe_on && (cmd_d == ST_IOWR));
        inta_n_d  = !(strobe_on && (cmd_d == ST_INTA));
        bus_to_d  = (state_q == S_T3) && (state_d == S_ABORT);
    end
endmodule

// File: tb/tb_i8288_busctl.sv
// Directed bench for i8288_busctl: u1 (TIMEOUT_CYCLES=4, HALT_ALE=0) is the main target,
// u0 (defaults) covers HALT ALE and the disabled watchdog.
module tb_i8288_busctl;
    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] status;
    logic       cen;
    int         tests = 0;
    int         fails = 0;

    logic ale0, mrdc0, mwtc0, iorc0, iowc0, inta0, den0, dtr0, bto0;
    logic ale1, mrdc1, mwtc1, iorc1, iowc1, inta1, den1, dtr1, bto1;
    logic [8:0] v0, v1;

    always #5 clk = ~clk;

    assign v0 = {ale0, mrdc0, mwtc0, iorc0, iowc0, inta0, den0, dtr0, bto0};
    assign v1 = {ale1, mrdc1, mwtc1, iorc1, iowc1, inta1, den1, dtr1, bto1};

    i8288_busctl u0 (
        .clk_i(clk), .reset_i(reset), .status_i(status), .cen_i(cen),
        .ale_o(ale0), .mrdc_n_o(mrdc0), .mwtc_n_o(mwtc0), .iorc_n_o(iorc0),
        .iowc_n_o(iowc0), .inta_n_o(inta0), .den_o(den0), .dt_r_o(dtr0), .bus_to_o(bto0)
    );

    i8288_busctl #(.TIMEOUT_CYCLES(4), .HALT_ALE(1'b0)) u1 (
        .clk_i(clk), .reset_i(reset), .status_i(status), .cen_i(cen),
        .ale_o(ale1), .mrdc_n_o(mrdc1), .mwtc_n_o(mwtc1), .iorc_n_o(iorc1),
        .iowc_n_o(iowc1), .inta_n_o(inta1), .den_o(den1), .dt_r_o(dtr1), .bus_to_o(bto1)
    );

    // Vector order: ALE, MRDC_N, MWTC_N, IORC_N, IOWC_N, INTA_N, DEN, DT_R, BUS_TO
    localparam logic [8:0] IDLEV = 9'b0_11111_0_1_0;
    localparam logic [8:0] RD_T1 = 9'b1_11111_0_0_0;
    localparam logic [8:0] WR_T1 = 9'b1_11111_0_1_0;
    localparam logic [8:0] MR_ON = 9'b0_01111_1_0_0;
    localparam logic [8:0] MW_ON = 9'b0_10111_1_1_0;
    localparam logic [8:0] IR_ON = 9'b0_11011_1_0_0;
    localparam logic [8:0] IW_ON = 9'b0_11101_1_1_0;
    localparam logic [8:0] IA_ON = 9'b0_11110_1_0_0;
    localparam logic [8:0] RD_OFF = 9'b0_11111_0_0_0;
    localparam logic [8:0] ABORT1 = 9'b0_11111_0_1_1;
    localparam logic [8:0] NO_DTR = 9'b1_11111_1_0_1;
`ifdef I8288_ADV_WR_EN
    localparam logic [8:0] MW_T2 = MW_ON;
    localparam logic [8:0] IW_T2 = IW_ON;
`else
    localparam logic [8:0] MW_T2 = 9'b0_11111_1_1_0;
    localparam logic [8:0] IW_T2 = 9'b0_11111_1_1_0;
`endif

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One clock, then check u1's outputs and that at most one strobe is low on each DUT
    task automatic step(input string tag, input logic [8:0] exp);
        logic [4:0] lo0, lo1;
        @(posedge clk);
        #1;
        chk(tag, v1, exp);
        lo0 = ~v0[7:3];
        lo1 = ~v1[7:3];
        tests++;
        assert ($countones(lo0) <= 1 && $countones(lo1) <= 1) else begin
            fails++;
            $error("FAIL %s_onehot observed=%b/%b expected=at most one low", tag, v0[7:3], v1[7:3]);
        end
    endtask

    initial begin
        reset  = 1'b1;
        status = 3'b101;
        cen    = 1'b1;
        step("rst0", IDLEV);
        step("rst1", IDLEV);
        step("rst2", IDLEV);
        chk("rst_u0", v0, IDLEV);
        reset  = 1'b0;
        status = 3'b111;
        step("idle", IDLEV);

        // Memory read
        status = 3'b101;
        step("mr_t1", RD_T1);
        step("mr_t2", MR_ON);
        step("mr_t3", MR_ON);
        status = 3'b111;
        step("mr_t4", IDLEV);
        step("mr_idle", IDLEV);

        // Memory write with one wait state
        status = 3'b110;
        step("mw_t1", WR_T1);
        step("mw_t2", MW_T2);
        step("mw_t3", MW_ON);
        step("mw_tw", MW_ON);
        status = 3'b111;
        step("mw_t4", IDLEV);
        step("mw_idle", IDLEV);

        // Back-to-back IORD then IOWR, next status driven in T4
        status = 3'b001;
        step("ir_t1", RD_T1);
        step("ir_t2", IR_ON);
        step("ir_t3", IR_ON);
        status = 3'b111;
        step("ir_t4", IDLEV);
        status = 3'b010;
        step("iw_t1", WR_T1);
        step("iw_t2", IW_T2);
        step("iw_t3", IW_ON);
        status = 3'b111;
        step("iw_t4", IDLEV);
        step("iw_idle", IDLEV);

        // Watchdog: IORD held 20 cycles
        status = 3'b001;
        step("to_t1", RD_T1);
        step("to_t2", IR_ON);
        for (int i = 0; i < 4; i++) step("to_t3", IR_ON);
        step("to_abort", ABORT1);
        step("to_abort2", IDLEV);
        chk("to_u0_held", v0, IR_ON);
        for (int i = 0; i < 12; i++) step("to_stay", IDLEV);
        chk("to_u0_end", v0, IR_ON);
        status = 3'b111;
        step("to_idle", IDLEV);
        chk("to_u0_t4", v0, IDLEV);
        step("to_idle2", IDLEV);

        // INTA with CEN dropped mid-command then restored
        status = 3'b000;
        step("ia_t1", RD_T1);
        step("ia_t2", IA_ON);
        cen = 1'b0;
        step("ia_t3_cen0", RD_OFF);
        cen = 1'b1;
        step("ia_tw_cen1", IA_ON);
        status = 3'b111;
        step("ia_t4", IDLEV);
        // INTA with CEN low throughout
        status = 3'b000;
        cen = 1'b0;
        step("ian_t1", RD_T1);
        step("ian_t2", RD_OFF);
        step("ian_t3", RD_OFF);
        status = 3'b111;
        step("ian_t4", IDLEV);
        cen = 1'b1;
        step("ian_idle", IDLEV);

        // HALT: no ALE on u1, ALE on u0, no strobe, no watchdog
        status = 3'b011;
        @(posedge clk); #1;
        chk("halt_t1_u1", v1 & NO_DTR, 9'b0_11111_0_0_0);
        chk("halt_t1_u0", v0 & NO_DTR, 9'b1_11111_0_0_0);
        for (int i = 0; i < 8; i++) step("halt_body", v1 & NO_DTR & ~NO_DTR | (v1 & 9'b0_00000_0_1_0) | 9'b0_11111_0_0_0);
        status = 3'b111;
        step("halt_t4", IDLEV);
        status = 3'b101;
        step("halt_next_t1", RD_T1);

        // Reset mid-cycle abandons the read
        step("rr_t2", MR_ON);
        reset = 1'b1;
        step("rr_rst", IDLEV);
        reset  = 1'b0;
        status = 3'b111;
        step("rr_idle", IDLEV);
        step("rr_idle2", IDLEV);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
